// File: rtl/mux_n_pipe.sv
// mux_n_pipe: NUM_IN-to-1 select stage feeding a 2-entry skid buffer with a
// valid/ready output handshake. ready_o is a register output.
// Optional feature macro: MUX_N_SEL_ERR_EN. When defined, an out-of-range
// select yields data 0 and an err flag that travels with the beat. When
// undefined, an out-of-range select picks the last input and err_o is 0.
module mux_n_pipe #(
    parameter int SIZE   = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_IN*SIZE-1:0] data_i,
    input  logic [SEL_W-1:0]       select_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [SIZE-1:0]        data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    input  logic                   flush_i,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state, next_state;
    logic            ready_q;
    logic [SIZE-1:0] main_data, skid_data, sel_data;
    logic            main_err, skid_err, sel_err;
    logic            accept, pop;
    logic            ld_main_in, ld_main_skid, ld_skid;

    assign accept  = valid_i && ready_q;
    assign pop     = (state != EMPTY) && ready_i;
    assign ready_o = ready_q;
    assign valid_o = (state != EMPTY);
    assign data_o  = main_data;
    assign err_o   = main_err;

`ifdef MUX_N_SEL_ERR_EN
    // Input select; any index without a matching input flags an error and yields 0.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int unsigned k = 0; k < unsigned'(NUM_IN); k++) begin
            if (select_i == SEL_W'(k)) begin
                sel_data = data_i[k*SIZE +: SIZE];
                sel_err  = 1'b0;
            end
        end
    end
`else
    // Input select; indices past the last input fall back to the last input.
    always_comb begin
        sel_data = data_i[(NUM_IN-1)*SIZE +: SIZE];
        sel_err  = 1'b0;
        for (int unsigned k = 0; k < unsigned'(NUM_IN); k++) begin
            if (select_i == SEL_W'(k)) begin
                sel_data = data_i[k*SIZE +: SIZE];
            end
        end
    end
`endif

    // State register; ready_o is registered from the next state so it is
    // low exactly while the skid entry is occupied.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != FULL);
        end
    end

    // Next-state and buffer load controls; flush overrides accept and pop.
    always_comb begin
        next_state   = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush_i) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        next_state = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        next_state = FULL;
                        ld_skid    = 1'b1;
                    end else if (pop) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        next_state   = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // Main (head) and skid data registers; main holds when nothing loads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (ld_main_in) begin
                main_data <= sel_data;
                main_err  <= sel_err;
            end else if (ld_main_skid) begin
                main_data <= skid_data;
                main_err  <= skid_err;
            end
            if (ld_skid) begin
                skid_data <= sel_data;
                skid_err  <= sel_err;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench for mux_n_pipe: a 4-input instance checked every cycle
// against a queue model of capacity two, plus a 3-input instance used for the
// out-of-range select case. Expectations follow MUX_N_SEL_ERR_EN if defined.
module tb_mux_n_pipe;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_i, flush_i;
    logic [63:0] data_i;
    logic [1:0]  select_i;
    logic        ready_o, valid_o, err_o;
    logic [15:0] data_o;

    logic [47:0] d3_i;
    logic [1:0]  sel3_i;
    logic        valid3_i;
    logic        ready3_o, valid3_o, err3_o;
    logic [15:0] data3_o;

    int checks   = 0;
    int failures = 0;
    beat_t q[$];

    always #5 clk = ~clk;

    mux_n_pipe #(.SIZE(16), .NUM_IN(4), .SEL_W(2)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .flush_i(flush_i), .err_o(err_o)
    );

    mux_n_pipe #(.SIZE(16), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk_i(clk), .rst_i(rst_i), .data_i(d3_i), .select_i(sel3_i),
        .valid_i(valid3_i), .ready_o(ready3_o), .data_o(data3_o), .valid_o(valid3_o),
        .ready_i(1'b1), .flush_i(1'b0), .err_o(err3_o)
    );

    function automatic beat_t ref_sel(input logic [63:0] din, input int sel, input int n);
        beat_t b;
        if (sel < n) begin
            b.d = din[sel*16 +: 16];
            b.e = 1'b0;
        end else begin
`ifdef MUX_N_SEL_ERR_EN
            b.d = 16'h0000;
            b.e = 1'b1;
`else
            b.d = din[(n-1)*16 +: 16];
            b.e = 1'b0;
`endif
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict accept/pop from the model, advance, then compare.
    task automatic cycle();
        bit    acc, pop;
        beat_t nb;
        acc = valid_i && (q.size() < 2);
        pop = (q.size() != 0) && ready_i;
        nb  = ref_sel(data_i, int'(select_i), 4);
        @(posedge clk);
        #1;
        if (rst_i || flush_i) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(nb);
        end
        check("valid_o", 32'(valid_o), 32'(q.size() != 0));
        check("ready_o", 32'(ready_o), 32'(q.size() < 2));
        if (q.size() != 0) begin
            check("data_o", 32'(data_o), 32'(q[0].d));
            check("err_o", 32'(err_o), 32'(q[0].e));
        end
    endtask

    task automatic offer(input logic [1:0] sel);
        valid_i  = 1'b1;
        select_i = sel;
        cycle();
    endtask

    initial begin
        beat_t e3;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
        data_i = 64'h4444_3333_2222_1111; select_i = 2'd0;
        d3_i = 48'hABCD_0002_0001; sel3_i = 2'd0; valid3_i = 1'b0;

        // Reset state
        cycle();
        cycle();
        rst_i = 1'b0;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);

        // Basic select, streaming with ready_i high
        offer(2'd0);
        check("sel0", 32'(data_o), 32'h1111);
        offer(2'd1);
        check("sel1", 32'(data_o), 32'h2222);
        offer(2'd2);
        check("sel2", 32'(data_o), 32'h3333);
        offer(2'd3);
        check("sel3", 32'(data_o), 32'h4444);
        valid_i = 1'b0;
        cycle();

        // Backpressure: A, B accepted, C held until the buffer drains
        ready_i = 1'b0;
        data_i = 64'h0000_CCCC_BBBB_AAAA;
        offer(2'd0);
        offer(2'd1);
        check("bp_ready_low", 32'(ready_o), 32'd0);
        offer(2'd2);
        offer(2'd2);
        check("bp_head_A", 32'(data_o), 32'hAAAA);
        ready_i = 1'b1;
        offer(2'd2);
        check("bp_head_B", 32'(data_o), 32'hBBBB);
        offer(2'd2);
        check("bp_head_C", 32'(data_o), 32'hCCCC);
        valid_i = 1'b0;
        cycle();
        check("bp_drained", 32'(valid_o), 32'd0);

        // Flush while full, with a beat offered in the flush cycle
        ready_i = 1'b0;
        offer(2'd0);
        offer(2'd1);
        flush_i = 1'b1;
        offer(2'd2);
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_ready", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        cycle();
        check("flush_no_C", 32'(valid_o), 32'd0);

        // Reset mid-operation, then a lone beat D
        ready_i = 1'b0;
        offer(2'd0);
        offer(2'd1);
        rst_i = 1'b1;
        offer(2'd2);
        rst_i = 1'b0;
        valid_i = 1'b0;
        check("mrst_valid", 32'(valid_o), 32'd0);
        check("mrst_data", 32'(data_o), 32'd0);
        check("mrst_ready", 32'(ready_o), 32'd1);
        check("mrst_err", 32'(err_o), 32'd0);
        ready_i = 1'b1;
        data_i = 64'h0000_0000_0000_D00D;
        offer(2'd0);
        check("mrst_D", 32'(data_o), 32'hD00D);
        valid_i = 1'b0;
        cycle();
        check("mrst_D_alone", 32'(valid_o), 32'd0);

        // Out-of-range select on the 3-input instance
        valid3_i = 1'b1;
        sel3_i = 2'd3;
        cycle();
        e3 = ref_sel({16'h0, d3_i}, 3, 3);
        check("oor_valid", 32'(valid3_o), 32'd1);
        check("oor_data", 32'(data3_o), 32'(e3.d));
        check("oor_err", 32'(err3_o), 32'(e3.e));
        sel3_i = 2'd2;
        cycle();
        check("inr_data", 32'(data3_o), 32'hABCD);
        check("inr_err", 32'(err3_o), 32'd0);
        check("inr_ready", 32'(ready3_o), 32'd1);
        valid3_i = 1'b0;
        cycle();

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            data_i   = {$urandom, $urandom};
            select_i = 2'($urandom_range(0, 3));
            valid_i  = ($urandom_range(0, 3) != 0);
            ready_i  = ($urandom_range(0, 2) != 0);
            flush_i  = ($urandom_range(0, 29) == 0);
            rst_i    = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-to-1 operand/forwarding select stage with a registered, elastic output: it selects one of NUM_IN SIZE-bit inputs by `select_i`, captures the result into a 2-entry skid buffer, and presents it with a valid/ready handshake. It generalises the 3:1 combinational select used in the pipelined datapath. It sits between forwarding/hazard logic and a consumer stage that can stall (`ready_i` low) or be flushed.

## Interface
- SIZE, 16, data width per input
- NUM_IN, 4, number of inputs (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- data_i  in  NUM_IN*SIZE  flattened inputs; input k at bits [k*SIZE +: SIZE]
- select_i  in  SEL_W  input index
- valid_i  in  1  upstream beat valid
- ready_o  out  1  stage can accept; registered
- data_o  out  SIZE  selected data of head beat
- valid_o  out  1  head beat valid
- ready_i  in  1  downstream accepts head beat
- flush_i  in  1  synchronous discard of all held and incoming beats
- err_o  out  1  head beat had out-of-range select (see Configuration)

## Operation
- Accept: `valid_i && ready_o`. Pop: `valid_o && ready_i`.
- Selected value: input `select_i` for in-range selects; out-of-range handling depends on MUX_N_SEL_ERR_EN.
- Storage: main register (drives outputs) + one skid register. States:
  - EMPTY: valid_o=0, ready_o=1. Accept -> ONE (beat into main).
  - ONE: valid_o=1, ready_o=1. Accept & pop -> ONE (new beat in main). Accept & no pop -> FULL (new beat into skid). Pop only -> EMPTY. Neither -> ONE, main held stable.
  - FULL: valid_o=1, ready_o=0. Pop -> ONE (skid moves to main). No pop -> FULL, all held.
- valid_i in FULL is ignored (no accept); upstream holds its beat.
- Ordering strictly FIFO; no beat dropped or duplicated except by flush/reset.
- flush_i: next state EMPTY regardless of accept/pop in the same cycle; a beat offered in the flush cycle is discarded. Flush has priority over everything except reset.
- data_o/err_o in EMPTY hold their last value (don't-care to consumer; bench checks only when valid_o=1).

## Timing
- Latency: accepted beat appears on data_o/valid_o the cycle after acceptance (EMPTY or ONE-with-pop).
- Throughput: 1 beat/cycle while ready_i=1.
- ready_o is a register output; it drops the cycle after the skid fills and rises the cycle after a pop from FULL.
- Reset values (cycle after rst_i high): valid_o=0, data_o=0, err_o=0, ready_o=1, state EMPTY, skid cleared. Reset mid-transfer discards both entries; no accept while rst_i=1.
- data_o and valid_o stable while valid_o=1 and ready_i=0.

## Configuration
- Macro MUX_N_SEL_ERR_EN.
- Defined: select_i >= NUM_IN yields data 0 and sets err flag carried with the beat through both buffer entries; err_o=1 while that beat is head.
- Undefined: select_i >= NUM_IN selects input NUM_IN-1 (default-to-last, matching the fixed 3:1 select); err_o tied 0.

## Test plan
- Basic select: SIZE=16, NUM_IN=4, inputs 0x1111/0x2222/0x3333/0x4444, ready_i=1, select 0,1,2,3 on consecutive cycles -> data_o 0x1111,0x2222,0x3333,0x4444 one cycle later each, valid_o continuous.
- Backpressure: ready_i=0, offer beats A,B,C back to back -> A,B accepted, ready_o=0 from cycle after B, C held; ready_i=1 -> A,B,C out in order, no loss.
- Simultaneous accept/pop in ONE: steady stream with ready_i=1 -> state stays ONE, ready_o never drops.
- Flush: FULL with A,B, flush_i=1 with valid_i=1 carrying C -> next cycle valid_o=0, ready_o=1; C never appears.
- Reset mid-operation: FULL, assert rst_i one cycle -> valid_o=0, data_o=0, ready_o=1, err_o=0; next beat D emerges alone.
- Out-of-range: NUM_IN=3, SEL_W=2, select 3, data2=0xABCD -> with MUX_N_SEL_ERR_EN data_o=0, err_o=1; without it data_o=0xABCD, err_o=0.
